// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and group generate/propagate helper for the pipelined CLA
package cla_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int GROUP_DEF = 4;
  localparam int MAXG = 32;
  typedef struct packed {
    logic gg;
    logic gp;
  } gp_t;
  // group generate/propagate over the low n bits of a slice
  function automatic gp_t grp_gp(input logic [MAXG-1:0] a, input logic [MAXG-1:0] b, input int n);
    gp_t r;
    r = '{gg: 1'b0, gp: 1'b1};
    for (int k = 0; k < MAXG; k++)
      if (k < n) begin
        r.gg = (a[k] & b[k]) | ((a[k] | b[k]) & r.gg);
        r.gp = r.gp & (a[k] | b[k]);
      end
    return r;
  endfunction
endpackage

// File: rtl/cla_group.sv
// cla_group: combinational G-bit carry-lookahead slice
module cla_group
  import cla_pkg::*;
#(
  parameter int G = GROUP_DEF
) (
  input  logic [G-1:0] a,
  input  logic [G-1:0] b,
  input  logic         c_in,
  output logic [G-1:0] sum,
  output logic         c_out,
  output logic         c_msb_in
);
  logic [G:0] c;
  gp_t t;
  if (G > MAXG) begin : g_chk
    $error("cla_group: G exceeds MAXG");
  end
  // every carry is a flat lookahead term over the bits below it
  always_comb begin
    c = '0;
    t = '0;
    for (int j = 0; j <= G; j++) begin
      t = grp_gp(MAXG'(a), MAXG'(b), j);
      c[j] = t.gg | (t.gp & c_in);
    end
  end
  assign sum = a ^ b ^ c[G-1:0];
  assign c_out = c[G];
  assign c_msb_in = c[G-1];
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead add/sub, one group per stage, valid/ready handshake
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GROUP = GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSTAGE = WIDTH / GROUP;
  if (WIDTH % GROUP != 0) begin : g_chk
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end
  logic             v  [NSTAGE];
  logic [WIDTH-1:0] ra [NSTAGE];
  logic [WIDTH-1:0] rb [NSTAGE];
  logic [WIDTH-1:0] rs [NSTAGE];
  logic             rc [NSTAGE];
  logic             rm [NSTAGE];
  logic             pv [NSTAGE];
  logic [WIDTH-1:0] pa [NSTAGE];
  logic [WIDTH-1:0] pb [NSTAGE];
  logic [WIDTH-1:0] ps [NSTAGE];
  logic             pc [NSTAGE];
  logic [WIDTH-1:0] ns [NSTAGE];
  logic [GROUP-1:0] ga [NSTAGE];
  logic [GROUP-1:0] gb [NSTAGE];
  logic [GROUP-1:0] gs [NSTAGE];
  logic             gc [NSTAGE];
  logic             gm [NSTAGE];
  logic [NSTAGE:0]  rdy;
  // stage inputs: stage 0 sees the conditioned operands, later stages the previous register
  always_comb begin
    pv[0] = in_valid;
    pa[0] = a;
    pb[0] = sub ? ~b : b;
    pc[0] = sub | cin;
    ps[0] = '0;
    for (int i = 1; i < NSTAGE; i++) begin
      pv[i] = v[i-1];
      pa[i] = ra[i-1];
      pb[i] = rb[i-1];
      pc[i] = rc[i-1];
      ps[i] = rs[i-1];
    end
    for (int i = 0; i < NSTAGE; i++) begin
      ga[i] = pa[i][i*GROUP +: GROUP];
      gb[i] = pb[i][i*GROUP +: GROUP];
    end
  end
  for (genvar g = 0; g < NSTAGE; g++) begin : g_grp
    cla_group #(.G(GROUP)) u_grp (
      .a        (ga[g]),
      .b        (gb[g]),
      .c_in     (pc[g]),
      .sum      (gs[g]),
      .c_out    (gc[g]),
      .c_msb_in (gm[g])
    );
  end
  // merge this stage's sum slice into the accumulated lower bits
  always_comb begin
    for (int i = 0; i < NSTAGE; i++) begin
      ns[i] = ps[i];
      ns[i][i*GROUP +: GROUP] = gs[i];
    end
  end
  // a stage can load when it is empty or its successor is loading
  always_comb begin
    rdy = '0;
    rdy[NSTAGE] = out_ready;
    for (int i = NSTAGE - 1; i >= 0; i--) rdy[i] = !v[i] || rdy[i+1];
  end
  // stage registers advance only when allowed; data holds otherwise
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSTAGE; i++) begin
      if (rst) begin
        v[i]  <= 1'b0;
        ra[i] <= '0;
        rb[i] <= '0;
        rs[i] <= '0;
        rc[i] <= 1'b0;
        rm[i] <= 1'b0;
      end else if (rdy[i]) begin
        v[i] <= pv[i];
        if (pv[i]) begin
          ra[i] <= pa[i];
          rb[i] <= pb[i];
          rs[i] <= ns[i];
          rc[i] <= gc[i];
          rm[i] <= gm[i];
        end
      end
    end
  end
  assign in_ready  = rdy[0];
  assign out_valid = v[NSTAGE-1];
  assign sum       = rs[NSTAGE-1];
  assign cout      = rc[NSTAGE-1];
  assign ovf       = rc[NSTAGE-1] ^ rm[NSTAGE-1];
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: scoreboard bench for 16-bit/4-stage and 4-bit/1-stage adders
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        iv, ir, ci, sb, ov, co, of;
  logic        ordy = 1'b1;
  logic [15:0] a, b, s;
  logic        iv4, ir4, ci4, sb4, ov4, co4, of4;
  logic        ordy4 = 1'b1;
  logic [3:0]  a4, b4, s4;
  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        lat;
    int          acc;
  } exp_t;
  exp_t q16[$];
  exp_t q4[$];
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  logic [15:0] va [8] = '{16'h1234, 16'hABCD, 16'h8000, 16'hFFFF, 16'h4000, 16'h0000, 16'h00FF, 16'h7FFF};
  logic [15:0] vb [8] = '{16'h1111, 16'h1234, 16'h0001, 16'hFFFF, 16'h4000, 16'h0001, 16'h0F01, 16'hFFFF};
  logic [15:0] ve [8] = '{16'h2345, 16'hBE02, 16'h7FFF, 16'hFFFE, 16'h8000, 16'hFFFF, 16'h1000, 16'h8000};
  logic [7:0]  vc = 8'b00000010;
  logic [7:0]  vs = 8'b10100100;
  logic [7:0]  ec = 8'b00001100;
  logic [7:0]  eo = 8'b10010100;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(ci), .sub(sb),
    .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co), .ovf(of)
  );
  cla_pipe_adder #(.WIDTH(4), .GROUP(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(ci4), .sub(sb4),
    .out_valid(ov4), .out_ready(ordy4), .sum(s4), .cout(co4), .ovf(of4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // offer one operand bundle from a negedge; push its expected result once accepted
  task automatic send(input bit w4, input logic [15:0] x, input logic [15:0] y, input logic c_,
                      input logic s_, input logic [15:0] es, input logic ec_, input logic eo_,
                      input logic lat);
    bit ok = 1'b0;
    if (w4) begin
      iv4 = 1'b1; a4 = x[3:0]; b4 = y[3:0]; ci4 = c_; sb4 = s_;
    end else begin
      iv = 1'b1; a = x; b = y; ci = c_; sb = s_;
    end
    for (int n = 0; n < 40 && !ok; n++) begin
      #1 ok = w4 ? ir4 : ir;
      @(negedge clk);
      if (ok) begin
        if (w4) q4.push_back('{es, ec_, eo_, lat, cyc});
        else q16.push_back('{es, ec_, eo_, lat, cyc});
      end
    end
    if (!ok) chk("send_ready", w4 ? ir4 : ir, 1);
  endtask

  // 16-bit monitor: pops on every output transfer and checks hold during stalls
  initial begin
    exp_t e;
    logic pst;
    logic [17:0] psv;
    pst = 1'b0;
    psv = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) pst = 1'b0;
      else begin
        if (pst) begin
          chk("hold16_valid", ov, 1);
          chk("hold16_data", {s, co, of}, psv);
        end
        if (ov && ordy) begin
          if (q16.size() == 0) chk("extra16_valid", ov, 0);
          else begin
            e = q16.pop_front();
            chk("sum16", s, e.s);
            chk("cout16", co, e.c);
            chk("ovf16", of, e.o);
            if (e.lat) chk("lat16", cyc - e.acc, 3);
          end
        end
        pst = ov && !ordy;
        psv = {s, co, of};
      end
    end
  end

  // 4-bit monitor: single-stage pipe, result follows the accepting edge directly
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ov4 && ordy4) begin
        if (q4.size() == 0) chk("extra4_valid", ov4, 0);
        else begin
          e = q4.pop_front();
          chk("sum4", s4, e.s);
          chk("cout4", co4, e.c);
          chk("ovf4", of4, e.o);
          if (e.lat) chk("lat4", cyc - e.acc, 0);
        end
      end
    end
  end

  initial begin
    iv = 0; a = 0; b = 0; ci = 0; sb = 0;
    iv4 = 0; a4 = 0; b4 = 0; ci4 = 0; sb4 = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", ov, 0);
    chk("rst_sum", s, 0);
    chk("rst_cout", co, 0);
    chk("rst_ovf", of, 0);
    chk("rst_valid4", ov4, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_rst", ir, 1);
    chk("ready_after_rst4", ir4, 1);
    @(negedge clk);
    send(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 1);
    send(0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
    send(0, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 1);
    send(0, 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 1);
    send(0, 16'h0005, 16'h0003, 1, 1, 16'h0002, 1, 0, 1);
    send(0, 16'h0003, 16'h0005, 0, 1, 16'hFFFE, 0, 0, 1);
    iv = 1'b0;
    send(1, 16'h0005, 16'h0003, 1, 0, 16'h0009, 0, 1, 1);
    send(1, 16'h000F, 16'h000F, 1, 0, 16'h000F, 1, 0, 1);
    iv4 = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        ordy = 1'b0;
        repeat (3) begin
          #1 chk("stall_in_ready", ir, 0);
          @(negedge clk);
        end
        ordy = 1'b1;
      end
      send(0, va[i], vb[i], vc[i], vs[i], ve[i], ec[i], eo[i], 0);
    end
    iv = 1'b0;
    repeat (8) @(negedge clk);
    send(0, 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0, 1);
    send(0, 16'h0010, 16'h0020, 0, 0, 16'h0030, 0, 0, 1);
    send(0, 16'h0100, 16'h0200, 0, 0, 16'h0300, 0, 0, 1);
    a = 16'hDEAD;
    b = 16'hBEEF;
    rst = 1'b1;
    q16.delete();
    @(negedge clk);
    #1;
    chk("flush_valid", ov, 0);
    chk("flush_sum", s, 0);
    rst = 1'b0;
    iv = 1'b0;
    chk("flush_in_ready", ir, 1);
    repeat (6) @(negedge clk);
    send(0, 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 1);
    iv = 1'b0;
    repeat (8) @(negedge clk);
    chk("q16_drained", q16.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
